// File: rtl/pa_dispatch_pkg.sv
// Shared dispatch definitions: functional-unit type codes, instruction field widths,
// the issue-scheduler state encoding and the packed instruction record.
package pa_dispatch_pkg;

  localparam int FTYPE_W   = 2;
  localparam int OPCODE_W  = 7;
  localparam int WBADDR_W  = 5;
  localparam int OPERAND_W = 16;

  localparam logic [FTYPE_W-1:0] FT_ARITH  = 2'd0;
  localparam logic [FTYPE_W-1:0] FT_LS     = 2'd1;
  localparam logic [FTYPE_W-1:0] FT_BRANCH = 2'd2;
  localparam logic [FTYPE_W-1:0] FT_REG    = 2'd3;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [FTYPE_W-1:0]   ftype;
    logic                 is_wb;
    logic [WBADDR_W-1:0]  wb_addr;
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] p_operand;
    logic [OPERAND_W-1:0] s_operand;
  } instr_t;

  // Branch and reg-stack units exist once and are only reachable from lane A.
  function automatic logic is_shared(input logic [FTYPE_W-1:0] ft);
    return (ft == FT_BRANCH) || (ft == FT_REG);
  endfunction

endpackage

// File: rtl/issue_slot_reg.sv
// Load-enabled register holding one instruction record; used for the hold slot
// and for both registered issue lanes.
module issue_slot_reg
  import pa_dispatch_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_load,
  input  instr_t i_d,
  output instr_t o_q
);

  instr_t r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/issue_scheduler.sv
// Two-wide issue scheduler: steers or serialises B-lane shared-unit ops onto lane A,
// serialises same-bundle WAW pairs and inserts bubbles while the lane-A target unit is busy.
module issue_scheduler
  import pa_dispatch_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enableA_i,
  input  logic                   enableB_i,
  input  logic [FTYPE_W-1:0]     functionalTypeA_i,
  input  logic [FTYPE_W-1:0]     functionalTypeB_i,
  input  logic                   isWbA_i,
  input  logic                   isWbB_i,
  input  logic [WBADDR_W-1:0]    wbAddressA_i,
  input  logic [WBADDR_W-1:0]    wbAddressB_i,
  input  logic [OPCODE_W-1:0]    opCodeA_i,
  input  logic [OPCODE_W-1:0]    opCodeB_i,
  input  logic [OPERAND_W-1:0]   pOperandA_i,
  input  logic [OPERAND_W-1:0]   sOperandA_i,
  input  logic [OPERAND_W-1:0]   pOperandB_i,
  input  logic [OPERAND_W-1:0]   sOperandB_i,
  input  logic                   branchBusy_i,
  input  logic                   regBusy_i,
  output logic                   stall_o,
  output logic                   enableA_o,
  output logic                   enableB_o,
  output logic [FTYPE_W-1:0]     functionalTypeA_o,
  output logic [FTYPE_W-1:0]     functionalTypeB_o,
  output logic                   isWbA_o,
  output logic                   isWbB_o,
  output logic [WBADDR_W-1:0]    wbAddressA_o,
  output logic [WBADDR_W-1:0]    wbAddressB_o,
  output logic [OPCODE_W-1:0]    opCodeA_o,
  output logic [OPCODE_W-1:0]    opCodeB_o,
  output logic [OPERAND_W-1:0]   pOperandA_o,
  output logic [OPERAND_W-1:0]   sOperandA_o,
  output logic [OPERAND_W-1:0]   pOperandB_o,
  output logic [OPERAND_W-1:0]   sOperandB_o,
  output logic [COUNT_WIDTH-1:0] splitCount_o,
  output logic [COUNT_WIDTH-1:0] stallCount_o
);

  function automatic logic unit_busy(input instr_t ins, input logic br_busy, input logic rg_busy);
    return ((ins.ftype == FT_BRANCH) && br_busy) || ((ins.ftype == FT_REG) && rg_busy);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sched_state_t            r_state, w_next_state;
  logic                    r_enA, r_enB;
  logic [COUNT_WIDTH-1:0]  r_split_cnt, r_stall_cnt;
  instr_t                  w_instA, w_instB, w_held, w_laneA, w_laneB, r_outA, r_outB;
  logic                    w_enA_n, w_enB_n, w_load_hold, w_split, w_bubble, w_stall;
  logic                    w_steer, w_conflict, w_cand_en;
  instr_t                  w_cand;

  assign w_instA = '{ftype: functionalTypeA_i, is_wb: isWbA_i, wb_addr: wbAddressA_i,
                     opcode: opCodeA_i, p_operand: pOperandA_i, s_operand: sOperandA_i};
  assign w_instB = '{ftype: functionalTypeB_i, is_wb: isWbB_i, wb_addr: wbAddressB_i,
                     opcode: opCodeB_i, p_operand: pOperandB_i, s_operand: sOperandB_i};

  assign w_steer    = !enableA_i && enableB_i && is_shared(functionalTypeB_i);
  assign w_conflict = enableA_i && enableB_i &&
                      (is_shared(functionalTypeB_i) ||
                       (isWbA_i && isWbB_i && (wbAddressA_i == wbAddressB_i)));
  assign w_cand     = w_steer ? w_instB : w_instA;
  assign w_cand_en  = enableA_i || w_steer;

  always_comb begin
    w_next_state = r_state;
    w_laneA      = w_instA;
    w_laneB      = w_instB;
    w_enA_n      = 1'b0;
    w_enB_n      = 1'b0;
    w_load_hold  = 1'b0;
    w_split      = 1'b0;
    w_bubble     = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_cand_en && unit_busy(w_cand, branchBusy_i, regBusy_i)) begin
          w_laneA  = w_cand;
          w_bubble = 1'b1;
          w_stall  = 1'b1;
        end else if (w_steer) begin
          w_laneA = w_instB;
          w_enA_n = 1'b1;
        end else if (w_conflict) begin
          // B is parked in the hold slot, so decode is free to move on this cycle.
          w_enA_n      = 1'b1;
          w_load_hold  = 1'b1;
          w_split      = 1'b1;
          w_next_state = DRAIN;
        end else begin
          w_enA_n = enableA_i;
          w_enB_n = enableB_i;
        end
      end
      DRAIN: begin
        w_stall = 1'b1;
        w_laneA = w_held;
        if (unit_busy(w_held, branchBusy_i, regBusy_i)) begin
          w_bubble = 1'b1;
        end else begin
          w_enA_n      = 1'b1;
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= RUN;
      r_enA       <= 1'b0;
      r_enB       <= 1'b0;
      r_split_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_enA   <= w_enA_n;
      r_enB   <= w_enB_n;
      if (w_split)  r_split_cnt <= sat_inc(r_split_cnt);
      if (w_bubble) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  issue_slot_reg u_hold (
    .i_clk(clock_i), .i_rst(reset_i), .i_load(w_load_hold), .i_d(w_instB), .o_q(w_held)
  );
  issue_slot_reg u_lane_a (
    .i_clk(clock_i), .i_rst(reset_i), .i_load(1'b1), .i_d(w_laneA), .o_q(r_outA)
  );
  issue_slot_reg u_lane_b (
    .i_clk(clock_i), .i_rst(reset_i), .i_load(1'b1), .i_d(w_laneB), .o_q(r_outB)
  );

  // Reset forces stall low even if the bundle was being held at the time.
  assign stall_o           = w_stall && !reset_i;
  assign enableA_o         = r_enA;
  assign enableB_o         = r_enB;
  assign functionalTypeA_o = r_outA.ftype;
  assign functionalTypeB_o = r_outB.ftype;
  assign isWbA_o           = r_outA.is_wb;
  assign isWbB_o           = r_outB.is_wb;
  assign wbAddressA_o      = r_outA.wb_addr;
  assign wbAddressB_o      = r_outB.wb_addr;
  assign opCodeA_o         = r_outA.opcode;
  assign opCodeB_o         = r_outB.opcode;
  assign pOperandA_o       = r_outA.p_operand;
  assign sOperandA_o       = r_outA.s_operand;
  assign pOperandB_o       = r_outB.p_operand;
  assign sOperandB_o       = r_outB.s_operand;
  assign splitCount_o      = r_split_cnt;
  assign stallCount_o      = r_stall_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with a per-cycle behavioural model and literal checkpoints.
module tb_issue_scheduler;
  import pa_dispatch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b0;
  logic        enableA_i = 0, enableB_i = 0, isWbA_i = 0, isWbB_i = 0;
  logic [1:0]  functionalTypeA_i = 0, functionalTypeB_i = 0;
  logic [4:0]  wbAddressA_i = 0, wbAddressB_i = 0;
  logic [6:0]  opCodeA_i = 0, opCodeB_i = 0;
  logic [15:0] pOperandA_i = 0, sOperandA_i = 0, pOperandB_i = 0, sOperandB_i = 0;
  logic        branchBusy_i = 0, regBusy_i = 0;
  logic        stall_o, enableA_o, enableB_o, isWbA_o, isWbB_o;
  logic [1:0]  functionalTypeA_o, functionalTypeB_o;
  logic [4:0]  wbAddressA_o, wbAddressB_o;
  logic [6:0]  opCodeA_o, opCodeB_o;
  logic [15:0] pOperandA_o, sOperandA_o, pOperandB_o, sOperandB_o;
  logic [15:0] splitCount_o, stallCount_o;

  issue_scheduler #(.COUNT_WIDTH(16)) dut (
    .clock_i(clk), .reset_i(reset_i),
    .enableA_i(enableA_i), .enableB_i(enableB_i),
    .functionalTypeA_i(functionalTypeA_i), .functionalTypeB_i(functionalTypeB_i),
    .isWbA_i(isWbA_i), .isWbB_i(isWbB_i),
    .wbAddressA_i(wbAddressA_i), .wbAddressB_i(wbAddressB_i),
    .opCodeA_i(opCodeA_i), .opCodeB_i(opCodeB_i),
    .pOperandA_i(pOperandA_i), .sOperandA_i(sOperandA_i),
    .pOperandB_i(pOperandB_i), .sOperandB_i(sOperandB_i),
    .branchBusy_i(branchBusy_i), .regBusy_i(regBusy_i),
    .stall_o(stall_o), .enableA_o(enableA_o), .enableB_o(enableB_o),
    .functionalTypeA_o(functionalTypeA_o), .functionalTypeB_o(functionalTypeB_o),
    .isWbA_o(isWbA_o), .isWbB_o(isWbB_o),
    .wbAddressA_o(wbAddressA_o), .wbAddressB_o(wbAddressB_o),
    .opCodeA_o(opCodeA_o), .opCodeB_o(opCodeB_o),
    .pOperandA_o(pOperandA_o), .sOperandA_o(sOperandA_o),
    .pOperandB_o(pOperandB_o), .sOperandB_o(sOperandB_o),
    .splitCount_o(splitCount_o), .stallCount_o(stallCount_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0] ft; logic wb; logic [4:0] wa; logic [6:0] op; logic [15:0] p, s;
  } ins_t;

  ins_t  pend[$];
  bit    m_started = 0;
  logic  e_enA = 0, e_enB = 0;
  ins_t  e_A, e_B;
  int    e_split = 0, e_stallc = 0;

  function automatic logic shared_unit(input logic [1:0] ft);
    return ft >= 2;
  endfunction

  function automatic logic unit_is_busy(input ins_t x);
    return (x.ft == FT_BRANCH && branchBusy_i) || (x.ft == FT_REG && regBusy_i);
  endfunction

  always @(negedge clk) begin
    ins_t a, b, c;
    logic exp_stall;
    #4;
    a = '{functionalTypeA_i, isWbA_i, wbAddressA_i, opCodeA_i, pOperandA_i, sOperandA_i};
    b = '{functionalTypeB_i, isWbB_i, wbAddressB_i, opCodeB_i, pOperandB_i, sOperandB_i};
    if (reset_i) begin
      chk("stall_in_reset", {31'd0, stall_o}, 32'd0);
      pend.delete();
      e_enA = 0; e_enB = 0; e_split = 0; e_stallc = 0;
      m_started = 1;
    end else if (m_started) begin
      e_enA = 0; e_enB = 0;
      if (pend.size() > 0) begin
        exp_stall = 1;
        c = pend[0];
        if (unit_is_busy(c)) begin
          if (e_stallc < 65535) e_stallc++;
        end else begin
          e_enA = 1; e_A = c;
          void'(pend.pop_front());
        end
      end else begin
        c = enableA_i ? a : b;
        exp_stall = (enableA_i || (enableB_i && shared_unit(b.ft))) && unit_is_busy(c);
        if (exp_stall) begin
          if (e_stallc < 65535) e_stallc++;
        end else if (enableA_i && enableB_i &&
                     (shared_unit(b.ft) || (a.wb && b.wb && a.wa == b.wa))) begin
          e_enA = 1; e_A = a;
          pend.push_back(b);
          if (e_split < 65535) e_split++;
        end else if (!enableA_i && enableB_i && shared_unit(b.ft)) begin
          e_enA = 1; e_A = b;
        end else begin
          e_enA = enableA_i; e_A = a;
          e_enB = enableB_i; e_B = b;
        end
      end
      chk("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_started) begin
      chk("enableA_o", {31'd0, enableA_o}, {31'd0, e_enA});
      chk("enableB_o", {31'd0, enableB_o}, {31'd0, e_enB});
      chk("splitCount_o", {16'd0, splitCount_o}, e_split);
      chk("stallCount_o", {16'd0, stallCount_o}, e_stallc);
      if (e_enA === 1'b1)
        chk("laneA_fields",
            {functionalTypeA_o, isWbA_o, wbAddressA_o, opCodeA_o, pOperandA_o[8:0]},
            {e_A.ft, e_A.wb, e_A.wa, e_A.op, e_A.p[8:0]});
      if (e_enA === 1'b1) chk("laneA_sop", {16'd0, sOperandA_o}, {16'd0, e_A.s});
      if (e_enB === 1'b1)
        chk("laneB_fields",
            {functionalTypeB_o, isWbB_o, wbAddressB_o, opCodeB_o, pOperandB_o[8:0]},
            {e_B.ft, e_B.wb, e_B.wa, e_B.op, e_B.p[8:0]});
      if (e_enB === 1'b1) chk("laneB_sop", {16'd0, sOperandB_o}, {16'd0, e_B.s});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic ea, input logic [1:0] ta, input logic wa, input logic [4:0] aa,
                       input logic [6:0] oa, input logic eb, input logic [1:0] tb,
                       input logic wb, input logic [4:0] ab, input logic [6:0] ob);
    @(negedge clk);
    enableA_i = ea; functionalTypeA_i = ta; isWbA_i = wa; wbAddressA_i = aa; opCodeA_i = oa;
    enableB_i = eb; functionalTypeB_i = tb; isWbB_i = wb; wbAddressB_i = ab; opCodeB_i = ob;
    pOperandA_i = 16'h1000 + 16'(oa); sOperandA_i = 16'h2000 + 16'(oa);
    pOperandB_i = 16'h3000 + 16'(ob); sOperandB_i = 16'h4000 + 16'(ob);
  endtask

  task automatic idle();
    drive(0, FT_ARITH, 0, 0, 0, 0, FT_ARITH, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk); reset_i = 1;
    idle(); idle();
    @(negedge clk); reset_i = 0;
    #3 chk("lit_reset_stall", {31'd0, stall_o}, 32'd0);
    chk("lit_reset_enA", {31'd0, enableA_o}, 32'd0);
    chk("lit_reset_split", {16'd0, splitCount_o}, 32'd0);

    // Independent pair issues on both lanes.
    drive(1, FT_ARITH, 1, 5'd3, 7'h05, 1, FT_LS, 1, 5'd4, 7'h20);
    #3 chk("lit_pair_stall", {31'd0, stall_o}, 32'd0);
    after_edge();
    chk("lit_pair_lanes", {enableA_o, enableB_o, 2'b00, opCodeA_o, 1'b0, opCodeB_o}, {2'b11, 2'b00, 7'h05, 1'b0, 7'h20});

    // B-lane branch is serialised behind A.
    drive(1, FT_ARITH, 1, 5'd1, 7'h01, 1, FT_BRANCH, 0, 5'd0, 7'h40);
    after_edge();
    chk("lit_split_c1", {enableA_o, enableB_o, opCodeA_o}, {2'b10, 7'h01});
    idle();
    #3 chk("lit_split_stall", {31'd0, stall_o}, 32'd1);
    after_edge();
    chk("lit_split_c2", {enableA_o, enableB_o, opCodeA_o}, {2'b10, 7'h40});
    chk("lit_split_cnt", {16'd0, splitCount_o}, 32'd1);
    idle();

    // Lone B-lane reg-stack op is steered onto lane A.
    drive(0, FT_ARITH, 0, 5'd0, 7'h00, 1, FT_REG, 0, 5'd0, 7'h60);
    after_edge();
    chk("lit_steer", {enableA_o, enableB_o, opCodeA_o}, {2'b10, 7'h60});
    chk("lit_steer_nosplit", {16'd0, splitCount_o}, 32'd1);

    // WAW on r7 serialised.
    drive(1, FT_ARITH, 1, 5'd7, 7'h11, 1, FT_ARITH, 1, 5'd7, 7'h12);
    after_edge();
    chk("lit_waw_c1", {enableA_o, enableB_o, opCodeA_o}, {2'b10, 7'h11});
    idle();
    after_edge();
    chk("lit_waw_c2", {enableA_o, opCodeA_o}, {1'b1, 7'h12});
    chk("lit_waw_cnt", {16'd0, splitCount_o}, 32'd2);

    // Branch on lane A held back three cycles by branchBusy_i.
    drive(1, FT_BRANCH, 0, 5'd0, 7'h41, 0, FT_ARITH, 0, 5'd0, 7'h00);
    branchBusy_i = 1;
    for (int i = 0; i < 3; i++) begin
      #3 chk("lit_busy_stall", {31'd0, stall_o}, 32'd1);
      after_edge();
      chk("lit_busy_bubble", {31'd0, enableA_o}, 32'd0);
      @(negedge clk);
    end
    branchBusy_i = 0;
    after_edge();
    chk("lit_busy_issue", {enableA_o, opCodeA_o}, {1'b1, 7'h41});
    chk("lit_busy_cnt", {16'd0, stallCount_o}, 32'd3);

    // Held reg-stack op waits one cycle in DRAIN for regBusy_i.
    drive(1, FT_ARITH, 1, 5'd5, 7'h14, 1, FT_REG, 0, 5'd0, 7'h61);
    idle();
    regBusy_i = 1;
    after_edge();
    chk("lit_drain_bubble", {31'd0, enableA_o}, 32'd0);
    @(negedge clk); regBusy_i = 0;
    after_edge();
    chk("lit_drain_issue", {enableA_o, opCodeA_o}, {1'b1, 7'h61});
    chk("lit_drain_cnt", {16'd0, stallCount_o}, 32'd4);

    // Reset while draining discards the held instruction.
    drive(1, FT_ARITH, 1, 5'd2, 7'h13, 1, FT_BRANCH, 0, 5'd0, 7'h42);
    @(negedge clk);
    reset_i = 1;
    enableA_i = 0; enableB_i = 0;
    after_edge();
    chk("lit_rst_en", {30'd0, enableA_o, enableB_o}, 32'd0);
    chk("lit_rst_split", {16'd0, splitCount_o}, 32'd0);
    @(negedge clk); reset_i = 0;
    #3 chk("lit_rst_run", {31'd0, stall_o}, 32'd0);
    after_edge();
    chk("lit_rst_no_held", {31'd0, enableA_o}, 32'd0);
    idle(); idle();

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
